muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
- Iterative multiply/divide controller for the EX stage. It executes MUL, DIVU and REMU, plus signed DIV/REM when the optional feature is compiled in.
- It reuses the shared 32-bit ALU for all arithmetic: ADD (4'b0000) for multiply, SUB (4'b0001) for divide.
- It borrows the ALU only while the pipeline grants it, and signals busy and done to the hazard unit.

Parameters:
- XLEN, 32, operand/result width; the ALU interface is fixed at 32.
- ITER, 32, iterations per operation; must equal XLEN.
- CNT_W, 6, iteration counter width; must be at least clog2(ITER)+1.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- req  in  1  start request, qualified by !busy
- op  in  3  op[1:0]: 00 MUL, 01 DIVU, 10 REMU, 11 reserved; op[2]: signed select
- src_a  in  32  multiplicand / dividend
- src_b  in  32  multiplier / divisor
- flush  in  1  abort the current operation (branch mispredict)
- alu_gnt  in  1  shared ALU is free this cycle
- alu_out  in  32  ALU result, combinational from alu_a/alu_b/alu_ctl
- alu_req  out  1  sequencer wants the ALU this cycle
- alu_a  out  32  ALU operand A
- alu_b  out  32  ALU operand B
- alu_ctl  out  4  ALU control code
- busy  out  1  operation in progress; pipeline must stall
- done  out  1  one-cycle pulse, result valid
- result  out  32  result, held until the next accept

Behaviour:
- Reset (async, any state): state=IDLE; busy=0, done=0, result=0, alu_req=0, alu_a=0, alu_b=0, alu_ctl=0; counter and internal registers cleared. Reset mid-operation discards the operation.
- State set: IDLE, CALC, DONE. busy = (state != IDLE).
- IDLE: req=1 is accepted at the clock edge.
  - Operands are latched and the counter is cleared.
  - Next state is CALC, except for the fast paths below, which go straight to DONE.
  - Fast paths: divisor==0 for DIV/DIVU/REM/REMU, and op[1:0]==11.
- CALC: alu_req=1. An iteration commits only on an edge where alu_gnt=1; with alu_gnt=0 all state holds (stall).
- MUL iteration (ALU ADD):
  - alu_a=acc, alu_b=mcand, alu_ctl=0000.
  - If mplier[0]=1, acc<=alu_out.
  - Then mcand<<=1 and mplier>>=1.
  - Result is the low 32 bits of the product; wrap-around is modulo 2^32.
- DIV iteration (restoring, ALU SUB):
  - rs={rem[30:0],quo[31]}; alu_a=rs, alu_b=divisor, alu_ctl=0001.
  - rem's shifted-out bit rem[31] is kept as a 33rd compare bit.
  - Internal compare: if {rem[31],rs} >= divisor, then rem<=alu_out and shift 1 into quo; otherwise rem<=rs and shift 0 into quo.
- After the ITER-th committed iteration, next state is DONE.
- DONE (exactly one cycle):
  - done=1; result register loaded with product, quotient or remainder per op.
  - busy=1 during DONE and falls on the next edge.
  - Next state is IDLE.
- Latency: accept at edge E0, then 32 granted CALC edges, then done=1 in the cycle after the 32nd edge. With no stalls, done is asserted 33 cycles after E0.
- Divide by zero: quotient=32'hFFFFFFFF, remainder=src_a; done asserted 1 cycle after accept.
- Reserved op: result=0; done asserted 1 cycle after accept.
- req while busy: ignored; no queueing.
- req in the DONE cycle: ignored; it may be re-asserted in the following IDLE cycle.
- flush in CALC or DONE: state=IDLE on the next edge; done suppressed; result keeps its previous value.
- flush and req together in IDLE: flush wins; the request is not accepted.
- Outside CALC: alu_req=0, alu_ctl=0000, alu_a=0, alu_b=0.

Optional Feature:
- Macro: SIGNED_MULDIV_EN.
- Defined:
  - op[2]=1 selects signed DIV/REM.
  - Operands are converted to magnitude internally at accept; quotient sign = sign_a XOR sign_b; remainder takes the dividend's sign, applied in DONE.
  - Overflow case 32'h80000000 / 32'hFFFFFFFF: quotient=32'h80000000, remainder=0.
  - Signed divide-by-zero follows the same rule as unsigned.
  - MUL is unaffected by op[2].
- Undefined: op[2] ignored; every op executes unsigned.

Decomposition:
- Shared package: MULDIV op encodings (MD_MUL, MD_DIVU, MD_REMU, MD_RSVD, MD_SIGNED bit); ALU control constants (ALU_ADD=4'b0000, ALU_SUB=4'b0001); state enum.
- Sub-module: muldiv_fsm (state register, iteration counter, grant/flush handling). The datapath registers stay in the top module.
- Bench: pairs the block with the existing ALU module.

Test Plan:
- MUL 7 x 6, alu_gnt=1 throughout -> done exactly 33 cycles after accept, result=42; MUL 32'hFFFFFFFF x 2 -> 32'hFFFFFFFE.
- DIVU 100/7 -> result=14; REMU 100/7 -> result=2; REMU 5/9 -> result=5.
- DIVU 123/0 -> done 1 cycle after accept, result=32'hFFFFFFFF; REMU 123/0 -> result=123.
- MUL 3 x 5 with alu_gnt low on every other CALC cycle -> done 65 cycles after accept, result=15; no state change on ungranted cycles.
- flush at CALC iteration 10, then reset asserted mid-DIVU on a fresh operation -> no done pulse; busy=0 next edge; all outputs 0 immediately on reset; new req accepted afterwards.
- With SIGNED_MULDIV_EN: DIV -7/2 -> result 32'hFFFFFFFD; REM -7/2 -> 32'hFFFFFFFF; DIV 32'h80000000/-1 -> 32'h80000000.

Source files
------------

// File: rtl/muldiv_sequencer_pkg.sv
// Shared definitions for the iterative multiply/divide sequencer:
// op encodings, shared-ALU control codes and the sequencer state type.
package muldiv_sequencer_pkg;

    localparam logic [1:0] MD_MUL  = 2'b00;
    localparam logic [1:0] MD_DIVU = 2'b01;
    localparam logic [1:0] MD_REMU = 2'b10;
    localparam logic [1:0] MD_RSVD = 2'b11;
    localparam int unsigned MD_SIGNED = 2;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic [31:0] magnitude(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/muldiv_fsm.sv
// Control half of the sequencer: state register, iteration counter and
// the grant/flush rules that decide when an iteration commits.
module muldiv_fsm
    import muldiv_sequencer_pkg::*;
#(
    parameter int ITER  = 32,
    parameter int CNT_W = 6
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   req_i,
    input  logic   flush_i,
    input  logic   alu_gnt_i,
    input  logic   fast_path_i,
    output state_e state_o,
    output logic   accept_o,
    output logic   commit_o,
    output logic   done_o
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // An iteration only advances on a granted edge; flush overrides everything.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        accept_o = 1'b0;
        commit_o = 1'b0;
        done_o   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (req_i && !flush_i) begin
                    accept_o = 1'b1;
                    cnt_d    = '0;
                    state_d  = fast_path_i ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: begin
                if (flush_i) begin
                    state_d = ST_IDLE;
                end else if (alu_gnt_i) begin
                    commit_o = 1'b1;
                    cnt_d    = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(ITER - 1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                done_o  = !flush_i;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign state_o = state_q;

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative MUL/DIVU/REMU sequencer borrowing the shared 32-bit ALU.
// Signed DIV/REM is compiled in when SIGNED_MULDIV_EN is defined.
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int ITER  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic            flush,
    input  logic            alu_gnt,
    input  logic [31:0]     alu_out,
    output logic            alu_req,
    output logic [31:0]     alu_a,
    output logic [31:0]     alu_b,
    output logic [3:0]      alu_ctl,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    state_e          state;
    logic            accept, commit, fast_path;
    logic [XLEN-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
    logic [XLEN-1:0] result_q, result_d, final_val, rs;
    logic [1:0]      op_q, op_d;
    logic            negq_q, negq_d, negr_q, negr_d;
    logic            ge;

    muldiv_fsm #(
        .ITER  (ITER),
        .CNT_W (CNT_W)
    ) u_fsm (
        .clk         (clk),
        .reset       (reset),
        .req_i       (req),
        .flush_i     (flush),
        .alu_gnt_i   (alu_gnt),
        .fast_path_i (fast_path),
        .state_o     (state),
        .accept_o    (accept),
        .commit_o    (commit),
        .done_o      (done)
    );

`ifndef SIGNED_MULDIV_EN
    logic unused_sign;
    assign unused_sign = op[MD_SIGNED];
`endif

    // a: accumulator / partial remainder, b: multiplicand / divisor,
    // c: multiplier / dividend-then-quotient.
    assign fast_path = (op[1:0] == MD_RSVD) || ((op[1:0] != MD_MUL) && (src_b == '0));
    assign rs        = {a_q[XLEN-2:0], c_q[XLEN-1]};
    assign ge        = {a_q[XLEN-1], rs} >= {1'b0, b_q};
    assign busy      = (state != ST_IDLE);
    assign result    = done ? final_val : result_q;

    always_comb begin
        alu_req = 1'b0;
        alu_a   = '0;
        alu_b   = '0;
        alu_ctl = ALU_ADD;
        if (state == ST_CALC) begin
            alu_req = 1'b1;
            alu_b   = b_q;
            if (op_q == MD_MUL) begin
                alu_a = a_q;
            end else begin
                alu_a   = rs;
                alu_ctl = ALU_SUB;
            end
        end
    end

    always_comb begin
        unique case (op_q)
            MD_MUL:  final_val = a_q;
            MD_DIVU: final_val = negq_q ? -c_q : c_q;
            MD_REMU: final_val = negr_q ? -a_q : a_q;
            default: final_val = '0;
        endcase
    end

    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        c_d      = c_q;
        op_d     = op_q;
        negq_d   = negq_q;
        negr_d   = negr_q;
        result_d = done ? final_val : result_q;
        if (accept) begin
            op_d   = op[1:0];
            negq_d = 1'b0;
            negr_d = 1'b0;
            if (op[1:0] == MD_MUL) begin
                a_d = '0;
                b_d = src_a;
                c_d = src_b;
            end else if (fast_path) begin
                // Divide-by-zero answers come straight out of the registers.
                a_d = src_a;
                b_d = '0;
                c_d = '1;
            end else begin
                a_d = '0;
                b_d = src_b;
                c_d = src_a;
`ifdef SIGNED_MULDIV_EN
                if (op[MD_SIGNED]) begin
                    b_d    = magnitude(src_b);
                    c_d    = magnitude(src_a);
                    negq_d = src_a[XLEN-1] ^ src_b[XLEN-1];
                    negr_d = src_a[XLEN-1];
                end
`endif
            end
        end else if (commit) begin
            if (op_q == MD_MUL) begin
                if (c_q[0]) begin
                    a_d = alu_out;
                end
                b_d = b_q << 1;
                c_d = c_q >> 1;
            end else if (ge) begin
                a_d = alu_out;
                c_d = {c_q[XLEN-2:0], 1'b1};
            end else begin
                a_d = rs;
                c_d = {c_q[XLEN-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            op_q     <= MD_MUL;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            result_q <= '0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            c_q      <= c_d;
            op_q     <= op_d;
            negq_q   <= negq_d;
            negr_q   <= negr_d;
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer paired with a behavioural ALU.
// Signed cases are exercised when SIGNED_MULDIV_EN is defined.
module tb_muldiv_sequencer;
    import muldiv_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        reset, req, flush, alu_gnt;
    logic [2:0]  op;
    logic [31:0] src_a, src_b, alu_out, alu_a, alu_b, result;
    logic [3:0]  alu_ctl;
    logic        alu_req, busy, done;

    int nChecks = 0;
    int nFail   = 0;

    always #5 clk = ~clk;

    // The shared ALU the sequencer borrows.
    always_comb begin
        case (alu_ctl)
            ALU_ADD: alu_out = alu_a + alu_b;
            ALU_SUB: alu_out = alu_a - alu_b;
            default: alu_out = 32'd0;
        endcase
    end

    muldiv_sequencer dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .op      (op),
        .src_a   (src_a),
        .src_b   (src_b),
        .flush   (flush),
        .alu_gnt (alu_gnt),
        .alu_out (alu_out),
        .alu_req (alu_req),
        .alu_a   (alu_a),
        .alu_b   (alu_b),
        .alu_ctl (alu_ctl),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic isSigned(input logic [2:0] o);
        logic s;
        s = 1'b0;
`ifdef SIGNED_MULDIV_EN
        s = o[2] && (o[1:0] != 2'b00);
`endif
        return s;
    endfunction

    function automatic logic [31:0] refResult(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic ovf;
        ovf = (a == 32'h80000000) && (b == 32'hFFFFFFFF);
        case (o[1:0])
            2'b00: return a * b;
            2'b01: begin
                if (b == 32'd0) return 32'hFFFFFFFF;
                if (isSigned(o)) return ovf ? 32'h80000000 : 32'($signed(a) / $signed(b));
                return a / b;
            end
            2'b10: begin
                if (b == 32'd0) return a;
                if (isSigned(o)) return ovf ? 32'd0 : 32'($signed(a) % $signed(b));
                return a % b;
            end
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] operandMag(input logic [2:0] o, input logic [31:0] v);
        if (isSigned(o) && v[31]) return 32'(-v);
        return v;
    endfunction

    // Transaction-level model: counts granted cycles and knows the answer up front.
    logic        m_busy = 1'b0, m_done = 1'b0;
    int          m_g = 0;
    logic [1:0]  m_op = 2'b00;
    logic [31:0] m_a = 32'd0, m_b = 32'd0, m_pend = 32'd0, m_result = 32'd0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy   <= 1'b0;
            m_done   <= 1'b0;
            m_g      <= 0;
            m_result <= 32'd0;
        end else if (!m_busy) begin
            if (req && !flush) begin
                m_busy <= 1'b1;
                m_op   <= op[1:0];
                m_g    <= 0;
                m_pend <= refResult(op, src_a, src_b);
                m_a    <= operandMag(op, src_a);
                m_b    <= operandMag(op, src_b);
                m_done <= (op[1:0] == 2'b11) || ((op[1:0] != 2'b00) && (src_b == 32'd0));
            end
        end else if (m_done) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            if (!flush) m_result <= m_pend;
        end else if (flush) begin
            m_busy <= 1'b0;
        end else if (alu_gnt) begin
            m_g <= m_g + 1;
            if (m_g == 31) m_done <= 1'b1;
        end
    end

    always @(negedge clk) begin : compare
        logic        calc, expDone;
        logic [31:0] expA, expB, expRes;
        logic [63:0] tmp;
        calc    = m_busy && !m_done;
        expDone = m_done && !flush;
        expRes  = expDone ? m_pend : m_result;
        expA    = 32'd0;
        expB    = 32'd0;
        if (calc) begin
            if (m_op == 2'b00) begin
                tmp  = 64'(m_a) * (64'(m_b) & ((64'd1 << m_g) - 64'd1));
                expA = tmp[31:0];
                expB = m_a << m_g;
            end else begin
                tmp  = (64'(m_a) >> (32 - m_g)) % 64'(m_b);
                tmp  = (tmp << 1) | 64'(m_a[31 - m_g]);
                expA = tmp[31:0];
                expB = m_b;
            end
        end
        checkOutput("cmp_busy", 32'(busy), 32'(m_busy));
        checkOutput("cmp_done", 32'(done), 32'(expDone));
        checkOutput("cmp_result", result, expRes);
        checkOutput("cmp_alu_req", 32'(alu_req), 32'(calc));
        checkOutput("cmp_alu_ctl", 32'(alu_ctl), (calc && m_op != 2'b00) ? 32'(ALU_SUB) : 32'(ALU_ADD));
        checkOutput("cmp_alu_a", alu_a, expA);
        checkOutput("cmp_alu_b", alu_b, expB);
    end

    task automatic applyStimulus(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                 input bit alt, input bit holdReq, input logic [31:0] expRes,
                                 input int expLat, input string nm);
        int k;
        bit seen;
        seen = 1'b0;
        @(posedge clk); #1;
        req = 1'b1; op = o; src_a = a; src_b = b; alu_gnt = 1'b1;
        @(posedge clk); #1;
        if (!holdReq) req = 1'b0;
        k = 1;
        while (!seen && k < 200) begin
            alu_gnt = alt ? (k % 2 == 0) : 1'b1;
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                checkOutput({nm, "_result"}, result, expRes);
                checkOutput({nm, "_latency"}, 32'(k), 32'(expLat));
            end else begin
                @(posedge clk); #1;
                k++;
            end
        end
        checkOutput({nm, "_done_seen"}, 32'(seen), 32'd1);
        @(posedge clk); #1;
        req = 1'b0; alu_gnt = 1'b1;
    endtask

    initial begin
        reset = 1'b1; req = 1'b0; flush = 1'b0; alu_gnt = 1'b1;
        op = 3'b000; src_a = 32'd0; src_b = 32'd0;
        #1;
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_result", result, 32'd0);
        checkOutput("reset_alu_req", 32'(alu_req), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        applyStimulus(3'b000, 32'd7, 32'd6, 0, 0, 32'd42, 33, "mul_7x6");
        applyStimulus(3'b000, 32'hFFFFFFFF, 32'd2, 0, 0, 32'hFFFFFFFE, 33, "mul_wrap");
        applyStimulus(3'b001, 32'd100, 32'd7, 0, 0, 32'd14, 33, "divu_100_7");
        applyStimulus(3'b010, 32'd100, 32'd7, 0, 0, 32'd2, 33, "remu_100_7");
        applyStimulus(3'b010, 32'd5, 32'd9, 0, 0, 32'd5, 33, "remu_5_9");
        applyStimulus(3'b001, 32'hFFFFFFFF, 32'd1, 0, 0, 32'hFFFFFFFF, 33, "divu_max_1");
        applyStimulus(3'b010, 32'hFFFFFFFF, 32'd10, 0, 0, 32'd5, 33, "remu_max_10");
        applyStimulus(3'b001, 32'h80000000, 32'd3, 0, 0, 32'h2AAAAAAA, 33, "divu_msb_3");
        applyStimulus(3'b001, 32'd123, 32'd0, 0, 0, 32'hFFFFFFFF, 1, "divu_by0");
        applyStimulus(3'b010, 32'd123, 32'd0, 0, 0, 32'd123, 1, "remu_by0");
        applyStimulus(3'b011, 32'd5, 32'd3, 0, 0, 32'd0, 1, "rsvd");
        applyStimulus(3'b000, 32'd3, 32'd5, 1, 0, 32'd15, 65, "mul_stall");
`ifdef SIGNED_MULDIV_EN
        applyStimulus(3'b101, 32'hFFFFFFF9, 32'd2, 0, 0, 32'hFFFFFFFD, 33, "div_m7_2");
        applyStimulus(3'b110, 32'hFFFFFFF9, 32'd2, 0, 0, 32'hFFFFFFFF, 33, "rem_m7_2");
        applyStimulus(3'b101, 32'h80000000, 32'hFFFFFFFF, 0, 0, 32'h80000000, 33, "div_ovf");
        applyStimulus(3'b110, 32'h80000000, 32'hFFFFFFFF, 0, 0, 32'd0, 33, "rem_ovf");
        applyStimulus(3'b101, 32'hFFFFFFF9, 32'd0, 0, 0, 32'hFFFFFFFF, 1, "div_by0");
        applyStimulus(3'b100, 32'hFFFFFFFF, 32'd3, 0, 0, 32'hFFFFFFFD, 33, "mul_sbit");
`else
        applyStimulus(3'b101, 32'hFFFFFFF9, 32'd2, 0, 0, 32'h7FFFFFFC, 33, "sbit_ignored");
`endif
        applyStimulus(3'b000, 32'd2, 32'd3, 0, 1, 32'd6, 33, "mul_holdreq");

        // Flush at iteration 10 with a stray request that must be ignored.
        @(posedge clk); #1;
        req = 1'b1; op = 3'b001; src_a = 32'd100; src_b = 32'd7;
        @(posedge clk); #1;
        req = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1; req = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; req = 1'b0;
        checkOutput("flush_busy", 32'(busy), 32'd0);
        checkOutput("flush_done", 32'(done), 32'd0);
        checkOutput("flush_result_kept", result, 32'd6);

        // flush beats req in IDLE.
        flush = 1'b1; req = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; req = 1'b0;
        checkOutput("flush_req_idle_busy", 32'(busy), 32'd0);

        // Async reset in the middle of a divide.
        @(posedge clk); #1;
        req = 1'b1; op = 3'b001; src_a = 32'd1000; src_b = 32'd3;
        @(posedge clk); #1;
        req = 1'b0;
        repeat (5) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_result", result, 32'd0);
        checkOutput("rst_alu_req", 32'(alu_req), 32'd0);
        checkOutput("rst_alu_a", alu_a, 32'd0);
        checkOutput("rst_alu_b", alu_b, 32'd0);
        checkOutput("rst_alu_ctl", 32'(alu_ctl), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        applyStimulus(3'b001, 32'd1000, 32'd3, 0, 0, 32'd333, 33, "divu_after_rst");

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
